drum_pipe_mult: RTL and testbench

- Pipelined, handshaked successor to the combinational DRUM approximate multiplier.
- Computes the DRUM product (a leading-one-anchored K-bit truncation of each operand with the LSB forced to 1, a KxK multiply, then a left shift) over three registered stages.
- Per transaction, it selects signed or unsigned operands and either approximate or exact multiplication.
- It carries a user tag so that it can sit inside streaming datapaths (filters, MAC arrays) with back-pressure.

---
 rtl/drum_pipe_mult.sv | 171 +++++++++++++++++
 tb/tb_drum_pipe_mult.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_pipe_mult.sv
// DRUM approximate (or exact) multiplier with signed/unsigned operands and a pass-through tag.
// Latency: 3 cycles from acceptance to out_valid. Throughput is one beat per cycle.
// Backpressure: the whole pipeline freezes when out_valid && !out_ready; in_ready = !out_valid || out_ready.
module drum_pipe_mult #(
  parameter int K     = 6,
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [M-1:0]     b,
  input  logic             signed_i,
  input  logic             exact_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   r,
  output logic [TAG_W-1:0] tag_o
);

  localparam int P  = N + M;
  localparam int SW = $clog2(N + M) + 1;
  localparam int W  = (N > M) ? N : M;
  localparam int KK = 2 * K;

  // Index of the most significant set bit; 0 for x == 0.
  function automatic int lead_one(input logic [W-1:0] x);
    int t;
    t = 0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) t = i;
    end
    return t;
  endfunction

  // Shift amount that brings the leading one down to bit K-1.
  function automatic logic [SW-1:0] trunc_sh(input logic [W-1:0] x);
    int t;
    t = lead_one(x);
    if (t > K - 1) return SW'(t - (K - 1));
    return '0;
  endfunction

  // K-bit window anchored at the leading one, LSB forced high to unbias the truncation.
  function automatic logic [K-1:0] trunc_mm(input logic [W-1:0] x);
    logic [W-1:0] sx;
    int t;
    t = lead_one(x);
    if (t > K - 1) begin
      sx = x >> (t - (K - 1));
      return sx[K-1:0] | K'(1);
    end
    return x[K-1:0];
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: magnitude, sign, truncation ----------------
  logic [N-1:0] mag_a;
  logic [M-1:0] mag_b;
  logic         neg_c;

  // Operand magnitudes and result sign for the incoming beat.
  always_comb begin
    mag_a = (signed_i && a[N-1]) ? (~a + N'(1)) : a;
    mag_b = (signed_i && b[M-1]) ? (~b + M'(1)) : b;
    neg_c = signed_i && (a[N-1] ^ b[M-1]) && (|a) && (|b);
  end

  logic             v1;
  logic [N-1:0]     ma1;
  logic [M-1:0]     mb1;
  logic [SW-1:0]    pa1, pb1;
  logic             neg1, ex1;
  logic [TAG_W-1:0] tag1;

  // Stage 1 register: full magnitudes in exact mode, K-bit windows plus shifts otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      ma1  <= '0;
      mb1  <= '0;
      pa1  <= '0;
      pb1  <= '0;
      neg1 <= 1'b0;
      ex1  <= 1'b0;
      tag1 <= '0;
    end else if (adv) begin
      v1   <= in_valid;
      neg1 <= neg_c;
      ex1  <= exact_i;
      tag1 <= tag_i;
      if (exact_i) begin
        ma1 <= mag_a;
        mb1 <= mag_b;
        pa1 <= '0;
        pb1 <= '0;
      end else begin
        ma1 <= N'(trunc_mm(W'(mag_a)));
        mb1 <= M'(trunc_mm(W'(mag_b)));
        pa1 <= trunc_sh(W'(mag_a));
        pb1 <= trunc_sh(W'(mag_b));
      end
    end
  end

  // ---------------- S2: multiply ----------------
  logic [KK-1:0] prod_apx;
  logic [P-1:0]  prod_ex;
  logic [P-1:0]  prod_sel;

  // Small KxK product for approximate beats, full NxM product for exact beats.
  always_comb begin
    prod_apx = KK'(ma1[K-1:0]) * KK'(mb1[K-1:0]);
    prod_ex  = P'(ma1) * P'(mb1);
    prod_sel = ex1 ? prod_ex : P'(prod_apx);
  end

  logic             v2;
  logic [P-1:0]     prod2;
  logic [SW-1:0]    sh2;
  logic             neg2;
  logic [TAG_W-1:0] tag2;

  // Stage 2 register: unsigned product and combined shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      prod2 <= '0;
      sh2   <= '0;
      neg2  <= 1'b0;
      tag2  <= '0;
    end else if (adv) begin
      v2    <= v1;
      prod2 <= prod_sel;
      sh2   <= pa1 + pb1;
      neg2  <= neg1;
      tag2  <= tag1;
    end
  end

  // ---------------- S3: shift, sign, output ----------------
  logic [P-1:0] shifted;
  logic [P-1:0] res;

  // Re-scale the product and restore its sign; the shift never pushes bits past P.
  always_comb begin
    shifted = prod2 << sh2;
    res     = neg2 ? (~shifted + P'(1)) : shifted;
  end

  // Output register: holds r/tag_o steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
      tag_o     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      r         <= res;
      tag_o     <= tag2;
    end
  end

endmodule

// File: tb/tb_drum_pipe_mult.sv
// Scoreboard bench for drum_pipe_mult: driver pushes expected results, monitor pops on each output transfer.
// Latency is checked on flagged beats; stalls are checked for stable outputs and in_ready low.
// out_ready is driven by the monitor from rdy_mode (always 1, random, or held 0).
module tb_drum_pipe_mult;
  localparam int K = 6, N = 16, M = 16, TW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, signed_i, exact_i, out_valid, out_ready;
  logic [N-1:0]  a;
  logic [M-1:0]  b;
  logic [TW-1:0] tag_i, tag_o;
  logic [N+M-1:0] r;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t q[$];

  drum_pipe_mult #(.K(K), .N(N), .M(M), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_i(signed_i), .exact_i(exact_i), .tag_i(tag_i),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .tag_o(tag_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  // Independent reference: repeated halving until the value fits in K bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input bit s, input bit e);
    longint unsigned mx, my, p, wx, wy;
    int sx, sy;
    mx = 64'(x);
    my = 64'(y);
    if (s && x[15]) mx = 65536 - mx;
    if (s && y[15]) my = 65536 - my;
    if (e) p = mx * my;
    else begin
      sx = 0;
      sy = 0;
      while ((mx >> sx) >= (64'd1 << K)) sx++;
      while ((my >> sy) >= (64'd1 << K)) sy++;
      wx = mx >> sx;
      wy = my >> sy;
      if (sx > 0) wx = wx | 64'd1;
      if (sy > 0) wy = wy | 64'd1;
      p = (wx * wy) << (sx + sy);
    end
    if (s && (x[15] ^ y[15])) p = 0 - p;
    return p[31:0];
  endfunction

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input bit s, input bit e,
                      input logic [3:0] tg, input logic [31:0] want, input bit lat);
    int n;
    exp_t ex;
    n = 0;
    @(negedge clk);
    a = ta; b = tb; signed_i = s; exact_i = e; tag_i = tg; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 1000 cycles");
    end else begin
      ex.r = want; ex.tag = tg; ex.acc = cyc; ex.lat = lat;
      q.push_back(ex);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk(name, 32'(q.size()), 32'd0);
  endtask

  // Monitor: drives out_ready, pops the scoreboard on each result transfer, checks stalls.
  initial begin
    bit prev_stall;
    logic [31:0] pr;
    logic [3:0]  pt;
    exp_t e;
    prev_stall = 1'b0;
    pr = '0;
    pt = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
      #1;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_r", r, pr);
        chk("stall_tag", 32'(tag_o), 32'(pt));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got r=0x%08h tag=%0d, expected no result", r, tag_o);
        end else begin
          e = q.pop_front();
          chk("result_r", r, e.r);
          chk("result_tag", 32'(tag_o), 32'(e.tag));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
        end
      end
      prev_stall = !rst && out_valid && !out_ready;
      pr = r;
      pt = tag_o;
    end
  end

  initial begin
    logic [15:0] ra, rb;
    bit rs, re;
    // Reset with a beat offered: it must be dropped.
    rst = 1'b1; in_valid = 1'b1; a = 16'd7; b = 16'd9;
    signed_i = 1'b0; exact_i = 1'b0; tag_i = 4'd5;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_r", r, 32'd0);
    chk("reset_tag", 32'(tag_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    chk("out_valid_after_reset", 32'(out_valid), 32'd0);

    // Directed vectors, back to back with mixed modes.
    send(16'd1000, 16'd3, 0, 0, 4'd1, 32'h00000BD0, 1);
    idle();
    drain("drain_t1");
    send(16'd1000, 16'd3, 0, 1, 4'd2, 32'h00000BB8, 0);
    send(16'hFC18, 16'd3, 1, 0, 4'd3, 32'hFFFFF430, 0);
    send(16'hFFFF, 16'hFFFF, 0, 0, 4'd4, 32'hF8100000, 0);
    send(16'h8000, 16'h8000, 1, 0, 4'd5, 32'h44100000, 0);
    send(16'h0000, 16'hFFFF, 0, 0, 4'd6, 32'h00000000, 0);
    send(16'h8000, 16'h8000, 1, 1, 4'd7, 32'h40000000, 0);
    send(16'd45, 16'd63, 0, 0, 4'd8, 32'h00000B13, 0);
    send(16'h0000, 16'hFFFF, 1, 0, 4'd9, 32'h00000000, 0);
    idle();
    drain("drain_directed");

    // Back-pressure: 8 tagged beats, 5-cycle stall mid-stream.
    rdy_mode = 0;
    fork
      for (int i = 0; i < 8; i++) begin
        ra = 16'(i * 4099 + 17);
        rb = 16'(i * 771 + 300);
        send(ra, rb, i[0], i[1], 4'(i), ref_mul(ra, rb, i[0], i[1]), 0);
      end
      begin
        repeat (5) @(negedge clk);
        #2 rdy_mode = 2;
        repeat (5) @(negedge clk);
        #2 rdy_mode = 0;
      end
    join
    idle();
    drain("drain_backpressure");

    // Reset with three beats in flight.
    rdy_mode = 2;
    send(16'd1111, 16'd2222, 0, 0, 4'd10, 32'd0, 0);
    send(16'd3333, 16'd4444, 0, 1, 4'd11, 32'd0, 0);
    send(16'd5555, 16'd6666, 0, 0, 4'd12, 32'd0, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_r", r, 32'd0);
    chk("midreset_tag", 32'(tag_o), 32'd0);
    rdy_mode = 0;
    send(16'd1000, 16'd3, 0, 0, 4'd13, 32'h00000BD0, 1);
    idle();
    drain("drain_after_reset");
    repeat (5) @(negedge clk);

    // Random regression with random back-pressure and bubbles.
    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) idle();
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      re = ($urandom_range(3) == 0);
      send(ra, rb, rs, re, 4'(i), ref_mul(ra, rb, rs, re), 0);
    end
    idle();
    rdy_mode = 0;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
